// File: rtl/machine_state_dumper.sv
// End-of-run dumper for `machine`: detects halt (zero instruction or cycle budget),
// then streams the register file, a data-memory window and a summary record.
module machine_state_dumper #(
  parameter int          NUM_REGS   = 32,
  parameter logic [31:0] MEM_BASE   = 32'h4000,
  parameter int          MEM_BYTES  = 4,
  parameter int          MAX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        hold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [31:0] out_data,
  output logic        halt_cause,
  output logic        done
);

  localparam int IDX_MAX = (NUM_REGS > MEM_BYTES) ? NUM_REGS : MEM_BYTES;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int CNT_W   = $clog2(MAX_CYCLES + 1);

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_RUN,
    S_DUMP_REG,
    S_DUMP_MEM,
    S_SUMMARY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      idx_q   <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  // Outputs are decoded purely from state plus the read-port data, so
  // out_ready never reaches out_valid combinationally.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    halt_d    = halt_q;
    rf_addr   = '0;
    mem_addr  = MEM_BASE;
    out_valid = 1'b0;
    out_kind  = 2'd0;
    out_data  = '0;
    hold      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_RUN: begin
        hold = 1'b0;
        if (inst == 32'h0) begin
          state_d = S_DUMP_REG;
          halt_d  = 1'b0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DUMP_REG;
            halt_d  = 1'b1;
          end
        end
      end

      S_DUMP_REG: begin
        rf_addr   = 5'(idx_q);
        out_valid = 1'b1;
        out_kind  = 2'd0;
        out_data  = rf_data;
        if (out_ready) begin
          if (idx_q == REG_LAST) begin
            state_d = S_DUMP_MEM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_DUMP_MEM: begin
        mem_addr  = MEM_BASE + 32'(idx_q);
        out_valid = 1'b1;
        out_kind  = 2'd1;
        out_data  = {24'b0, mem_data};
        if (out_ready) begin
          if (idx_q == MEM_LAST) begin
            state_d = S_SUMMARY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_SUMMARY: begin
        out_valid = 1'b1;
        out_kind  = 2'd2;
        out_data  = {halt_q, 23'b0, 8'(cnt_q)};
        if (out_ready) state_d = S_DONE;
      end

      S_DONE: begin
        done = 1'b1;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign halt_cause = halt_q;

endmodule

// File: tb/tb_machine_state_dumper.sv
// Directed bench for machine_state_dumper: register-file and memory models
// drive the read ports; every record is compared to hand-derived values.
module tb_machine_state_dumper;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        hold;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_data;
  logic        halt_cause;
  logic        done;

  logic [31:0] rf [32];
  logic [7:0]  mem [4];

  int n_checks = 0;
  int n_fail   = 0;

  machine_state_dumper dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .hold       (hold),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_data   (out_data),
    .halt_cause (halt_cause),
    .done       (done)
  );

  assign rf_data  = rf[rf_addr];
  assign mem_data = (mem_addr >= 32'h4000 && mem_addr < 32'h4004) ? mem[mem_addr[1:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, 32'(hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_kind"}, 32'(out_kind), 32'd0);
    check({tag, "_data"}, out_data, 32'h0);
    check({tag, "_cause"}, 32'(halt_cause), 32'd0);
    check({tag, "_rfaddr"}, 32'(rf_addr), 32'd0);
    check({tag, "_memaddr"}, mem_addr, 32'h0000_4000);
  endtask

  // Streams all 37 records; bp selects the 1,0,0,1 ready pattern.
  task automatic run_dump(input string tag, input logic [31:0] summ, input bit bp);
    int k;
    int c;
    logic [1:0]  ekind;
    logic [31:0] edata;
    k = 0;
    c = 0;
    while (k < 37 && c < 300) begin
      out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      if (k < 32) begin
        ekind = 2'd0;
        edata = rf[k];
      end else if (k < 36) begin
        ekind = 2'd1;
        edata = 32'h11 * (k - 31);
        check($sformatf("%s_rec%0d_addr", tag, k), mem_addr, 32'h4000 + (k - 32));
      end else begin
        ekind = 2'd2;
        edata = summ;
      end
      check($sformatf("%s_rec%0d_valid", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s_rec%0d_kind", tag, k), 32'(out_kind), 32'(ekind));
      check($sformatf("%s_rec%0d_data", tag, k), out_data, edata);
      @(posedge clk);
      #2;
      if (out_ready) k++;
      c++;
    end
    check({tag, "_records"}, k, 37);
    check({tag, "_cycles"}, c, bp ? 73 : 37);
    out_ready = 1'b0;
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_hold_after"}, 32'(hold), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | i;
    rf[15] = 32'hFFFF_FFFF;
    rf[16] = 32'h0000_007F;
    rf[17] = 32'h7FFF_FFFF;
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;

    reset     = 1'b0;
    inst      = 32'h1;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("por");

    // Zero-instruction halt on the 5th edge after release.
    reset = 1'b1;
    repeat (4) tick();
    check("zi_pre_hold", 32'(hold), 32'd0);
    check("zi_pre_valid", 32'(out_valid), 32'd0);
    inst = 32'h0;
    tick();
    inst = 32'h1;
    #1;
    check("zi_hold", 32'(hold), 32'd1);
    check("zi_valid", 32'(out_valid), 32'd1);
    check("zi_cause", 32'(halt_cause), 32'd0);
    check("zi_rfaddr", 32'(rf_addr), 32'd0);
    run_dump("zi", 32'h0000_0004, 1'b0);

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("post%0d_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("post%0d_done", i), 32'(done), 32'd1);
    end

    // Cycle-budget halt.
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst2");
    reset = 1'b1;
    inst  = 32'hDEAD_BEEF;
    repeat (63) tick();
    check("bud_pre_hold", 32'(hold), 32'd0);
    check("bud_pre_valid", 32'(out_valid), 32'd0);
    tick();
    check("bud_hold", 32'(hold), 32'd1);
    check("bud_valid", 32'(out_valid), 32'd1);
    check("bud_cause", 32'(halt_cause), 32'd1);
    run_dump("bud", 32'h8000_0040, 1'b0);
    check("bud_cause_end", 32'(halt_cause), 32'd1);

    // Zero instruction on the same edge the budget expires, with backpressure.
    reset = 1'b0;
    #1;
    check_reset_outputs("rst3");
    reset = 1'b1;
    inst  = 32'h1;
    repeat (63) tick();
    check("sim_pre_hold", 32'(hold), 32'd0);
    inst = 32'h0;
    tick();
    inst = 32'h1;
    #1;
    check("sim_hold", 32'(hold), 32'd1);
    check("sim_cause", 32'(halt_cause), 32'd0);
    run_dump("bp", 32'h0000_003F, 1'b1);

    // Reset during register record 10, then a fresh run.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    inst  = 32'h0;
    tick();
    inst = 32'h1;
    out_ready = 1'b1;
    repeat (10) tick();
    check("mid_rfaddr", 32'(rf_addr), 32'd10);
    check("mid_data", out_data, 32'hA500_000A);
    check("mid_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    out_ready = 1'b0;
    repeat (2) tick();
    check("mid_run_valid", 32'(out_valid), 32'd0);
    inst = 32'h0;
    tick();
    inst = 32'h1;
    #1;
    check("mid_restart_rfaddr", 32'(rf_addr), 32'd0);
    check("mid_restart_data", out_data, 32'hA500_0000);
    run_dump("mid", 32'h0000_0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/machine_state_dumper.md
# machine_state_dumper

- Sits directly downstream of `machine` and consumes its architectural state at end of run.
- Watches the fetched instruction and a cycle budget to detect end of simulation.
- Then walks the register file and a small data-memory window through read ports, emitting one 32-bit record per handshake on a valid/ready stream.
- Replaces the ad-hoc end-of-run dump with a synthesizable, checkable block feeding the autograder log.

## Interface
Parameters:
- `NUM_REGS`, 32: registers dumped, index 0..NUM_REGS-1.
- `MEM_BASE`, 32'h4000: first byte address of the dumped memory window.
- `MEM_BYTES`, 4: bytes dumped from MEM_BASE upward.
- `MAX_CYCLES`, 64: run-cycle budget before forced halt.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `inst` in 32: instruction currently fetched by `machine`.
- `rf_addr` out 5: register-file read index, combinational read.
- `rf_data` in 32: register contents at `rf_addr`, same cycle.
- `mem_addr` out 32: data-memory byte address, combinational read.
- `mem_data` in 8: byte at `mem_addr`, same cycle.
- `hold` out 1: high from halt onward; integrator gates `machine` clock-enable with it.
- `out_valid` out 1: record present.
- `out_ready` in 1: consumer accepts record.
- `out_kind` out 2: 0 = register, 1 = memory byte, 2 = summary.
- `out_data` out 32: record payload.
- `halt_cause` out 1: 0 = zero instruction, 1 = cycle budget.
- `done` out 1: all records accepted; sticky until reset.

## Operation
States: RUN, DUMP_REG, DUMP_MEM, SUMMARY, DONE.

Reset:
- Async assert (reset=0) forces RUN, cycle counter 0, index 0.
- All outputs reset to 0; `rf_addr` and `mem_addr` reset to 0 / MEM_BASE respectively.

RUN:
- Each rising edge with `inst` != 0: cycle counter increments, saturating at MAX_CYCLES.
- Edge where `inst` == 32'h0: go to DUMP_REG with halt_cause=0.
- Edge where counter == MAX_CYCLES-1 and `inst` != 0: go to DUMP_REG with halt_cause=1.
- Both conditions on the same edge: zero instruction wins, halt_cause=0.
- `hold` rises on the same edge as leaving RUN.

DUMP_REG:
- `rf_addr` = index; `out_valid`=1, `out_kind`=0, `out_data`=`rf_data`.
- On valid&&ready: index increments.
- Acceptance at index NUM_REGS-1: go to DUMP_MEM with index cleared.

DUMP_MEM:
- `mem_addr` = MEM_BASE+index; `out_data` = {24'b0, `mem_data`}, `out_kind`=1.
- Acceptance at MEM_BYTES-1: go to SUMMARY.

SUMMARY:
- One record: `out_kind`=2, `out_data` = {halt_cause, 23'b0, cycle_count[7:0]}.
- Acceptance: go to DONE.

DONE:
- `out_valid`=0, `done`=1, `hold`=1 until reset.

Handshake rules:
- `out_valid` never deasserts without acceptance.
- `out_data`/`out_kind` are stable while valid && !ready.
- `out_ready` is ignored when `out_valid`=0.

Width rules:
- Index counter is wide enough for max(NUM_REGS, MEM_BYTES).
- Cycle counter is clog2(MAX_CYCLES+1) bits and never wraps.

## Timing
- Halt latency: halt condition sampled at edge N gives `out_valid`=1 and `hold`=1 after edge N.
- Throughput: one record per cycle with `out_ready` held high.
- Total dump: NUM_REGS+MEM_BYTES+1 accepted records; `done` rises the edge after the last acceptance.
- Backpressure: each cycle of `out_ready`=0 adds exactly one cycle; no records lost or duplicated.
- Reset mid-dump: outputs drop to 0 asynchronously; after release the block restarts in RUN with counters cleared and no partial record reissued.
- Combinational paths: `rf_data`/`mem_data` to `out_data` only; none from `out_ready` to `out_valid`.

## Test plan
- Halt on zero instruction: `inst`=0 on 5th edge after reset release, r15=-1, r16=127, r17=2147483647, ready=1.
  - Records 15/16/17 = 0xFFFFFFFF/0x0000007F/0x7FFFFFFF.
  - Summary = 0x00000004; `done` after 37 accepted records.
- Budget halt: `inst` never 0, MAX_CYCLES=64.
  - Halt at edge 64; summary = 0x80000040; `hold` high from then on.
- Simultaneous: `inst`=0 on the edge the counter hits 63.
  - halt_cause=0.
- Backpressure: `out_ready` toggles 1,0,0,1 repeatedly.
  - All 37 records in order, each stable across stall cycles; mem bytes 0x11,0x22,0x33,0x44 at 0x4000..0x4003 emitted as 0x00000011..0x00000044.
- Reset mid-dump: assert reset during register record 10.
  - All outputs 0 immediately.
  - After release, a fresh run re-dumps starting at r0.
- Post-done: `out_ready`=1 for 20 further cycles.
  - `out_valid` stays 0, `done` stays 1.
